// File: rtl/dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter
//   Round-robin arbiter in front of one shared W-bit register. Each requester
//   raises its req bit. The arbiter grants one requester for one cycle. At the
//   end of that cycle it writes that requester's wdata slice into q. It then
//   spends one cool-down cycle before it arbitrates again, so grants are at
//   least three cycles apart.
//
//   Optional feature, enabled when the macro ARB_LOCK_EN is defined:
//     a lock input. While lock is high during a grant cycle, the same
//     requester keeps the grant, q reloads every cycle and the round-robin
//     pointer does not advance.
//
// Ports
//   clk    in  1      rising-edge clock
//   rst    in  1      synchronous active-high reset
//   lock   in  1      hold current grant (only when ARB_LOCK_EN is defined)
//   req    in  N      level request, bit i = requester i
//   wdata  in  N*W    packed write data, requester i at [i*W +: W]
//   gnt    out N      registered one-hot grant
//   q      out W      shared register contents
//   busy   out 1      registered, high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module dff_bank_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
`ifdef ARB_LOCK_EN
  input  logic           lock,
`endif
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COOL  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_win;
  logic [PW-1:0] w_win_nxt;
  logic [PW-1:0] w_pick;
  logic [PW-1:0] w_idx;
  logic          w_found;
  logic          w_hold;
  logic [N-1:0]  r_gnt;
  logic [N-1:0]  w_gnt_nxt;
  logic [W-1:0]  r_q;
  logic          r_busy;

  // Compute (v + 1) mod N for pointer and search index arithmetic.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    if (v == PW'(N - 1)) begin
      r = {PW{1'b0}};
    end else begin
      r = v + PW'(1);
    end
    return r;
  endfunction

`ifdef ARB_LOCK_EN
  assign w_hold = lock;
`else
  assign w_hold = 1'b0;
`endif

  // Round-robin search: the first requester with req high, starting at r_ptr
  // and wrapping from N-1 back to 0.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = r_ptr;
    for (int k = 0; k < N; k++) begin
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end else begin
        w_found = w_found;
      end
      w_idx = wrap_inc(w_idx);
    end
  end

  // Next-state, next-winner and next-grant decode.
  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_gnt_nxt   = {N{1'b0}};
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_win_nxt   = w_pick;
          w_gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << w_pick;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GRANT: begin
        // A locked grant re-enters GRANT with the same winner. The write that
        // ends this cycle still happens in the sequential block below.
        if (w_hold) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = r_gnt;
        end else begin
          w_state_nxt = COOL;
        end
      end
      COOL: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, grant, busy, pointer and shared-register updates. Reset
  // takes priority over the write of a GRANT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= {N{1'b0}};
      r_q     <= {W{1'b0}};
      r_busy  <= 1'b0;
      r_ptr   <= {PW{1'b0}};
      r_win   <= {PW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_win   <= w_win_nxt;
      if (r_state == GRANT) begin
        r_q <= wdata[int'(r_win)*W +: W];
        if (!w_hold) begin
          r_ptr <= wrap_inc(r_win);
        end
      end
    end
  end

  assign gnt  = r_gnt;
  assign q    = r_q;
  assign busy = r_busy;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dff_bank_arbiter
//   Self-checking bench for dff_bank_arbiter (N=4, W=8). A transaction-level
//   reference model tracks the granted requester, the cool-down cycle, the
//   round-robin pointer and the shared register contents. Directed scenarios
//   also check fixed constants. A randomized phase checks the DUT against the
//   model. Define ARB_LOCK_EN to exercise the lock feature.
// -----------------------------------------------------------------------------
module tb_dff_bank_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           lock = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           busy;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: current grantee (-1 when none), cool-down flag,
  // next search start and register value.
  int         m_cur  = -1;
  bit         m_cool = 1'b0;
  int         m_ptr  = 0;
  logic [W-1:0] m_q  = '0;

  dff_bank_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef ARB_LOCK_EN
    .lock  (lock),
`endif
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .q     (q),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] one;
    one = 1;
    return (m_cur >= 0) ? (one << m_cur) : '0;
  endfunction

  function automatic logic exp_busy();
    return (m_cur >= 0) || m_cool;
  endfunction

  // Advance one clock: update the model from the inputs at the edge,
  // then return at the following falling edge, where outputs are sampled.
  task automatic tick();
    bit hold;
    @(posedge clk);
`ifdef ARB_LOCK_EN
    hold = lock;
`else
    hold = 1'b0;
`endif
    if (rst) begin
      m_cur = -1; m_cool = 1'b0; m_ptr = 0; m_q = '0;
    end else if (m_cur >= 0) begin
      m_q = wdata[m_cur*W +: W];
      if (!hold) begin
        m_ptr = (m_cur + 1) % N; m_cur = -1; m_cool = 1'b1;
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_cur < 0 && req[(m_ptr + k) % N]) m_cur = (m_ptr + k) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; lock = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; wdata = 32'hDEADBEEF;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_run++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt cyc %0d got %b want 0000", c, gnt); end
      n_run++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q cyc %0d got %h want 00", c, q); end
      n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy cyc %0d got %b want 0", c, busy); end
    end
  endtask

  task automatic test_single();
    logic [N-1:0]   g_want [3] = '{4'b0100, 4'b0000, 4'b0000};
    logic [W-1:0]   q_want [3] = '{8'h00, 8'hA5, 8'hA5};
    logic           b_want [3] = '{1'b1, 1'b1, 1'b0};
    rst = 1'b0; req = 4'b0100; wdata = '0; wdata[2*W +: W] = 8'hA5;
    for (int c = 0; c < 3; c++) begin
      tick();
      req = 4'b0000;
      n_run++; if (gnt !== g_want[c]) begin n_fail++; $display("FAIL single_gnt cyc %0d got %b want %b", c, gnt, g_want[c]); end
      n_run++; if (q !== q_want[c]) begin n_fail++; $display("FAIL single_q cyc %0d got %h want %h", c, q, q_want[c]); end
      n_run++; if (busy !== b_want[c]) begin n_fail++; $display("FAIL single_busy cyc %0d got %b want %b", c, busy, b_want[c]); end
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] one;
    one = 1;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) wdata[i*W +: W] = 8'h10 + 8'(i);
    for (int c = 0; c < 15; c++) begin
      tick();
      if (c % 3 == 0) begin
        n_run++; if (gnt !== (one << ((c / 3) % N))) begin n_fail++; $display("FAIL fair_gnt cyc %0d got %b want %b", c, gnt, one << ((c / 3) % N)); end
      end else begin
        n_run++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL fair_gap cyc %0d got %b want 0000", c, gnt); end
      end
      if (c % 3 == 1) begin
        n_run++; if (q !== 8'h10 + 8'((c / 3) % N)) begin n_fail++; $display("FAIL fair_q cyc %0d got %h want %h", c, q, 8'h10 + 8'((c / 3) % N)); end
      end
      n_run++; if (gnt !== exp_gnt()) begin n_fail++; $display("FAIL fair_model cyc %0d got %b want %b", c, gnt, exp_gnt()); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b1000;
    tick();
    n_run++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_first got %b want 1000", gnt); end
    req = 4'b1001;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 3) begin
        n_run++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_to0 got %b want 0001", gnt); end
      end
      if (c == 6) begin
        n_run++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_to3 got %b want 1000", gnt); end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0010; wdata = '0; wdata[1*W +: W] = 8'h77;
    tick();
    n_run++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL midrst_grant got %b want 0010", gnt); end
    rst = 1'b1;
    tick();
    n_run++; if (q !== 8'h00) begin n_fail++; $display("FAIL midrst_q got %h want 00", q); end
    n_run++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL midrst_gnt got %b want 0000", gnt); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    rst = 1'b0; req = 4'b1111;
    tick();
    n_run++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL midrst_next got %b want 0001", gnt); end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    req = 4'b0100; wdata = '0;
    tick();
    for (int c = 1; c <= 4; c++) begin
      n_run++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL lock_gnt cyc %0d got %b want 0100", c, gnt); end
      n_run++; if (q !== 8'((c > 3) ? 3 : c - 1)) begin n_fail++; $display("FAIL lock_q cyc %0d got %h want %h", c, q, 8'((c > 3) ? 3 : c - 1)); end
      wdata[2*W +: W] = 8'((c > 3) ? 3 : c);
      lock = (c <= 3);
      req = (c == 4) ? 4'b1111 : 4'b0100;
      tick();
    end
    n_run++; if (gnt !== 4'b0000 || q !== 8'h03) begin n_fail++; $display("FAIL lock_end got gnt %b q %h want 0000 03", gnt, q); end
    tick(); tick();
    n_run++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL lock_next got %b want 1000", gnt); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 49) == 0);
      req   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      wdata = 32'($urandom);
`ifdef ARB_LOCK_EN
      lock  = ($urandom_range(0, 2) == 0);
`endif
      tick();
      n_run++; if (gnt !== exp_gnt()) begin n_fail++; $display("FAIL rand_gnt cyc %0d got %b want %b", c, gnt, exp_gnt()); end
      n_run++; if (q !== m_q) begin n_fail++; $display("FAIL rand_q cyc %0d got %h want %h", c, q, m_q); end
      n_run++; if (busy !== exp_busy()) begin n_fail++; $display("FAIL rand_busy cyc %0d got %b want %b", c, busy, exp_busy()); end
      n_run++; if ($countones(gnt) > 1) begin n_fail++; $display("FAIL rand_onehot cyc %0d got %b want at most one bit", c, gnt); end
    end
    rst = 1'b0; lock = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_mid_reset();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
